// File: rtl/freq_div_meter_pkg.sv
// freq_div_meter_pkg
//   Shared constants and width helpers for the integer clock divider and its
//   measurement counterpart, so both sides derive identical counter widths.
//   Contents:
//     clog2()        - ceil(log2(value)), never less than 1
//     meter_width()  - width of a counter that must hold 0..max_div
//     DEFAULT_*      - default parameter values used by the meter and its interface
package freq_div_meter_pkg;

    localparam int DEFAULT_MAX_DIV  = 256;
    localparam int DEFAULT_LOCK_CNT = 4;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (remain > 0) begin
                result = result + 1;
                remain = remain >> 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // A count of MAX_DIV itself must be representable, hence the +1.
    function automatic int meter_width(input int max_div);
        return clog2(max_div + 1);
    endfunction

endpackage

// File: rtl/freq_div_meter_if.sv
// freq_div_meter_if
//   Bundles the measured clock, enable and measurement results of one
//   freq_div_meter instance.
//   Signals:
//     CLK_div    - clock under measurement (may be asynchronous to CLK_in)
//     EN         - synchronous enable; low holds the meter in its reset state
//     PERIOD     - last rise-to-rise period, in CLK_in cycles
//     HIGH_TIME  - CLK_in cycles the synchronized CLK_div was high in that period
//     VALID      - one-cycle strobe marking an update of PERIOD/HIGH_TIME
//     LOCKED     - LOCK_CNT consecutive identical periods seen
//     TIMEOUT    - no rising edge within MAX_DIV cycles
//   Modports: master drives CLK_div/EN and observes results; slave is the meter.
//
//   Handshake: VALID is a pure strobe with no ready/backpressure. It is high
//   for exactly one CLK_in cycle per report and never in two consecutive
//   cycles; PERIOD, HIGH_TIME and LOCKED are stable and belong together in the
//   VALID cycle, and PERIOD/HIGH_TIME hold until the next report or clear.
interface freq_div_meter_if
    import freq_div_meter_pkg::*;
#(
    parameter int WIDTH = meter_width(DEFAULT_MAX_DIV)
);

    logic             CLK_div;
    logic             EN;
    logic [WIDTH-1:0] PERIOD;
    logic [WIDTH-1:0] HIGH_TIME;
    logic             VALID;
    logic             LOCKED;
    logic             TIMEOUT;

    modport master (
        output CLK_div,
        output EN,
        input  PERIOD,
        input  HIGH_TIME,
        input  VALID,
        input  LOCKED,
        input  TIMEOUT
    );

    modport slave (
        input  CLK_div,
        input  EN,
        output PERIOD,
        output HIGH_TIME,
        output VALID,
        output LOCKED,
        output TIMEOUT
    );

endinterface

// File: rtl/freq_div_meter_sync_edge_det.sv
// sync_edge_det
//   Two-flop synchronizer followed by an edge flop, for bringing an
//   asynchronous level into the CLK_in domain and detecting its rising edge.
//   Ports:
//     CLK_in   - sampling clock (rising edge)
//     RST      - asynchronous, active-low reset; all flops clear to 0
//     i_async  - asynchronous input level
//     o_lvl    - synchronized level
//     o_rise   - one-cycle pulse on a synchronized 0->1 transition
module sync_edge_det (
    input  logic CLK_in,
    input  logic RST,
    input  logic i_async,
    output logic o_lvl,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_lvl  = r_s2;
    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_div_meter.sv
// freq_div_meter
//   Measures the rise-to-rise period and high time of CLK_div in CLK_in
//   cycles, recovering the ratio and duty cycle produced by an integer clock
//   divider. Reports after every rising edge (except the arming one), flags
//   lock after LOCK_CNT identical periods, and flags a timeout when no edge
//   arrives within MAX_DIV cycles.
//   Parameters:
//     MAX_DIV   - largest measurable period in CLK_in cycles (>= 2)
//     LOCK_CNT  - consecutive identical periods needed for LOCKED (>= 1)
//   Ports:
//     CLK_in    - reference clock, all logic on its rising edge
//     RST       - asynchronous, active-low reset
//     bus       - freq_div_meter_if slave: CLK_div/EN in, results out
module freq_div_meter
    import freq_div_meter_pkg::*;
#(
    parameter int MAX_DIV  = DEFAULT_MAX_DIV,
    parameter int LOCK_CNT = DEFAULT_LOCK_CNT
) (
    input  logic              CLK_in,
    input  logic              RST,
    freq_div_meter_if.slave   bus
);

    localparam int WIDTH = meter_width(MAX_DIV);
    localparam int MW    = clog2(LOCK_CNT + 1);

    localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MAX_DIV);
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

    logic w_lvl;
    logic w_rise;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;
    logic             r_armed;
    logic [MW-1:0]    r_match;

    logic [MW-1:0]    w_match_next;
    logic             w_cnt_max;

    sync_edge_det u_sync (
        .CLK_in  (CLK_in),
        .RST     (RST),
        .i_async (bus.CLK_div),
        .o_lvl   (w_lvl),
        .o_rise  (w_rise)
    );

    // Match count that a report at this edge would produce. r_period still
    // holds the previous report, so comparing it with r_cnt tests whether
    // the period just ended repeats the last one. match==0 means there is no
    // previous period to compare with, so the first report always counts.
    always_comb begin
        w_cnt_max    = (r_cnt == CNT_MAX);
        w_match_next = MATCH_ONE;
        if ((r_match == '0) || (r_cnt == r_period)) begin
            if (r_match == MATCH_MAX) begin
                w_match_next = MATCH_MAX;
            end else begin
                w_match_next = r_match + MATCH_ONE;
            end
        end
    end

    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_armed     <= 1'b0;
            r_match     <= '0;
        end else if (!bus.EN) begin
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_armed     <= 1'b0;
            r_match     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_rise) begin
                // A rise always restarts both counters; it takes priority
                // over the timeout check, so a period of exactly MAX_DIV is
                // reported normally.
                r_cnt  <= CNT_ONE;
                r_hcnt <= CNT_ONE;
                if (r_armed) begin
                    r_period    <= r_cnt;
                    r_high_time <= r_hcnt;
                    r_valid     <= 1'b1;
                    r_match     <= w_match_next;
                    r_locked    <= (w_match_next == MATCH_MAX);
                end else begin
                    // First rise after reset/enable/timeout only opens a
                    // measurement window; there is no complete period yet.
                    r_armed   <= 1'b1;
                    r_timeout <= 1'b0;
                end
            end else begin
                if (!w_cnt_max) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                if (w_lvl && (r_hcnt != CNT_MAX)) begin
                    r_hcnt <= r_hcnt + CNT_ONE;
                end
                if (w_cnt_max) begin
                    r_timeout <= 1'b1;
                    r_locked  <= 1'b0;
                    r_match   <= '0;
                    r_armed   <= 1'b0;
                end
            end
        end
    end

    assign bus.PERIOD    = r_period;
    assign bus.HIGH_TIME = r_high_time;
    assign bus.VALID     = r_valid;
    assign bus.LOCKED    = r_locked;
    assign bus.TIMEOUT   = r_timeout;

endmodule

// File: doc/freq_div_meter.md
# freq_div_meter

Measures the integer frequency-division ratio and high time of a divided clock `CLK_div` against the reference clock `CLK_in`. It is the checking counterpart of the integer frequency divider: it recovers the factor DIV and the duty cycle that the divider produced. The block reports the period after every rising edge and asserts lock after repeated identical periods. It sits beside clock-divider instances as an on-chip monitor and bench checker.

## Interface
- `MAX_DIV`, default 256: largest measurable period in `CLK_in` cycles, ≥2.
- `LOCK_CNT`, default 4: number of consecutive identical periods required for lock, ≥1.
- `WIDTH`, derived as clog2(MAX_DIV+1): width of the measurement outputs.
- `CLK_in`, input, 1: reference clock. All logic is on its rising edge.
- `RST`, input, 1: asynchronous, active-low reset.
- `CLK_div`, input, 1: clock under measurement. It may be asynchronous to `CLK_in`.
- `EN`, input, 1: synchronous enable. When low, the block is held in its reset state.
- `PERIOD`, output, WIDTH: last measured rise-to-rise period in `CLK_in` cycles.
- `HIGH_TIME`, output, WIDTH: number of `CLK_in` cycles the synchronized `CLK_div` was high in that period.
- `VALID`, output, 1: one-cycle pulse when `PERIOD` and `HIGH_TIME` update.
- `LOCKED`, output, 1: set when LOCK_CNT consecutive identical periods have been measured.
- `TIMEOUT`, output, 1: set when no rising edge arrives within MAX_DIV cycles.

## Operation
- **Synchronizer.** Two flops, then one edge flop; all reset to 0. `rise` = s2 & ~s3. `lvl` = s2.
- **Period counter `cnt`.** On `rise`, `cnt` ← 1. Otherwise `cnt` ← `cnt`+1, saturating at MAX_DIV.
- **High counter `hcnt`.** On `rise`, `hcnt` ← 1. Otherwise, if `lvl`=1, `hcnt` ← `hcnt`+1 (saturating); if `lvl`=0, `hcnt` holds.
- **`armed` flag.** Set by the first `rise` after reset, enable or timeout. That first `rise` produces no report.
- **Report.** On `rise` with `armed`=1:
  - `PERIOD` ← `cnt`, `HIGH_TIME` ← `hcnt`, `VALID` ← 1.
- **Lock tracking with `match`**, range 0..LOCK_CNT, on each report:
  - If `match`=0 or `cnt`==`PERIOD` (the previous value), `match` ← min(`match`+1, LOCK_CNT).
  - Otherwise `match` ← 1 and `LOCKED` ← 0.
  - `LOCKED` ← 1 when the new `match` equals LOCK_CNT.
- **Timeout.** When `cnt`==MAX_DIV and `rise`=0:
  - `TIMEOUT` ← 1, `LOCKED` ← 0, `match` ← 0, `armed` ← 0.
  - The next `rise` clears `TIMEOUT` and re-arms the block without reporting.
- **Simultaneous `rise` and `cnt`==MAX_DIV.** `rise` wins. A period of exactly MAX_DIV is reported normally.
- **`EN`=0.** Counters, `armed`, `match`, `LOCKED`, `TIMEOUT` and `VALID` clear, exactly as on reset. The synchronizer keeps running. `PERIOD` and `HIGH_TIME` clear to 0.
- **Reset values.** `PERIOD`=0, `HIGH_TIME`=0, `VALID`=0, `LOCKED`=0, `TIMEOUT`=0. `cnt` and `hcnt` are 0.

## Timing
- Latency: a `CLK_div` high level sampled at `CLK_in` edge t0 produces `rise` in the cycle after edge t1.
  - Outputs update at edge t2, so `VALID` is high for the cycle following t2.
- For a `CLK_div` generated synchronously from the same `CLK_in` by the integer divider:
  - `PERIOD` = DIV exactly.
  - `HIGH_TIME` = floor(DIV/2).
- For an asynchronous `CLK_div`, successive periods may jitter by ±1 cycle; lock is then not guaranteed.
- `VALID` is never high in two consecutive cycles; the minimum spacing is 2 cycles (DIV=2).
- `RST` asserted mid-period clears all state immediately. The first report after release needs two detected rises.

## Structure
- Shared package: the `clog2` constant function (ceil log2, minimum 1) and the WIDTH derivation, so divider and meter agree on widths.
- One natural sub-module: `sync_edge_det`, containing the 2-flop synchronizer plus edge flop, with outputs `lvl` and `rise`. It is reusable for other asynchronous monitors.
- Top level holds the counters, `armed`/`match` logic and output registers, about 150–200 lines.

## Test plan
- **Lock on DIV=5.** Drive from the divider with DIV=5 and SYNC=1, LOCK_CNT=4, MAX_DIV=256.
  - Each `VALID` shows `PERIOD`=5, `HIGH_TIME`=2.
  - `LOCKED` rises with the 4th report, i.e. the 5th detected rise.
- **Minimum divide.** DIV=2.
  - `PERIOD`=2, `HIGH_TIME`=1.
  - `VALID` pulses every other cycle.
  - `LOCKED` after 4 reports.
- **Ratio change.** Switch the divider from DIV=6 to DIV=9 while locked.
  - The first mismatching report clears `LOCKED` in the same cycle as `VALID`.
  - `LOCKED` returns after 4 reports of 9, each with `HIGH_TIME`=4.
- **Timeout.** Stop `CLK_div` low with MAX_DIV=16.
  - `TIMEOUT`=1 and `LOCKED`=0 exactly 16 cycles after the last `rise`.
  - On restart, the first rise clears `TIMEOUT` with no `VALID`; the second rise reports.
- **Enable and reset mid-period.** Pull `EN` low, then separately pull `RST` low, each mid-period while locked.
  - All outputs go to 0: on the next edge for `EN`, immediately for `RST`.
  - After release, no `VALID` occurs until two rises have been detected.
